button_event_scheduler: RTL and testbench
=========================================

BUTTON_EVENT_SCHEDULER -- requirements
Module: Button_Event_Scheduler

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_LIMIT, default 250000, which is the number of consecutive clocks a raw input must differ from its filtered state before that state changes (legal range 2..2^20).
REQ-002 The block SHALL have port i_Clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_Rst_L, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have port i_Bouncy, input, 4 bits, the raw switch levels, one per channel and asynchronous to nothing (pre-synchronised).
REQ-005 The block SHALL have port o_Debounced, output, 4 bits, the filtered level per channel.
REQ-006 The block SHALL have port o_Event_Valid, output, 1 bit, which is high while a press event is offered.
REQ-007 The block SHALL have port o_Event_Id, output, 2 bits, the channel of the offered event.
REQ-008 The block SHALL have port i_Event_Ready, input, 1 bit, the consumer's accept signal.
REQ-009 The block SHALL have port o_Overrun, output, 4 bits, a sticky per-channel lost-press flag.

Function
REQ-010 Each channel SHALL have its own counter, ceil(log2(DEBOUNCE_LIMIT)) bits wide: if raw equals state, then counter <= 0; if raw differs and counter < LIMIT-1, then counter increments; if raw differs and counter == LIMIT-1, then state <= raw and counter <= 0.
REQ-011 A filtered state change SHALL therefore occur on the LIMIT-th consecutive rising edge that samples raw != state; any single-cycle return to agreement restarts the count from 0.
REQ-012 A 0->1 filtered transition on channel n SHALL set pending[n] on the same edge on which o_Debounced[n] rises; a 1->0 transition SHALL create no event.
REQ-013 If pending[n] is already 1 when a new press on channel n is detected, o_Overrun[n] SHALL set to 1 and stay set until reset; pending[n] SHALL stay 1 (the events merge).
REQ-014 The arbiter FSM SHALL have two states: IDLE (o_Event_Valid=0) and OFFER (o_Event_Valid=1).
REQ-015 In IDLE with any pending bit set, the FSM SHALL go to OFFER on the next edge, load o_Event_Id with the first pending channel found searching ptr, ptr+1, ... mod 4, and clear that pending bit.
REQ-016 In OFFER, o_Event_Id and o_Event_Valid SHALL hold stable until an edge with i_Event_Ready=1 (the handshake).
REQ-017 On a handshake, ptr SHALL become (o_Event_Id+1) mod 4; if any pending bit is set, the FSM SHALL stay in OFFER and load the next winner on the same edge, searching from the new ptr (back-to-back, one event per clock); otherwise it SHALL go to IDLE.
REQ-018 If a press sets pending[n] on the same edge that a load clears pending[n], the set SHALL win, pending[n] SHALL remain 1, and overrun SHALL NOT be flagged.
REQ-019 i_Event_Ready while in IDLE SHALL be ignored.
REQ-020 Latency from the press edge to o_Event_Valid high SHALL be 1 clock when the FSM is in IDLE.
REQ-021 Round-robin SHALL guarantee that each pending channel is offered within 4 handshakes.

Reset
REQ-022 While i_Rst_L=0 at an edge, all counters, o_Debounced, pending, ptr, o_Overrun, o_Event_Id and o_Event_Valid SHALL go to 0, and the FSM SHALL go to IDLE.
REQ-023 Reset asserted during OFFER SHALL drop o_Event_Valid without a handshake; the event is discarded.
REQ-024 An input held high through reset release SHALL be treated as a new press: o_Debounced rises after LIMIT edges and an event is generated.

Verification (DEBOUNCE_LIMIT=4, i_Event_Ready=1 unless stated)
REQ-025 Glitch rejection: i_Bouncy[0] high 1 clk, low 1 clk, then high 6 clks -> o_Debounced[0] rises on the 4th edge of the final high run; one event with Id=0 and Valid high for exactly 1 clk.
REQ-026 Short pulse: i_Bouncy[2] high for 3 clks -> o_Debounced stays 0 and no event is produced.
REQ-027 Simultaneous presses: channels 0, 1 and 3 rise on the same edge, ptr=0 -> Ids 0, 1, 3 on three consecutive clocks with Valid continuous, then IDLE; ptr ends at 0.
REQ-028 Backpressure: Ready=0 with Id=1 offered, then channel 1 presses twice (release and re-press, each held 4 clks) -> first re-press sets pending, second sets o_Overrun[1]=1; Id stays 1 until Ready.
REQ-029 Fairness: ptr=2, pending {0,3} -> Id=3 first, then Id=0.
REQ-030 Reset mid-offer: i_Rst_L=0 for 1 clk during OFFER -> all outputs 0 on the next edge; no event is reissued unless a new press occurs.

Source files
------------

// File: rtl/button_event_scheduler_if.sv
// ============================================================================
// Module   : button_event_scheduler_if
// Brief    : Raw switch inputs, filtered levels and press-event handshake
//            bundled between the scheduler and its consumer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface button_event_scheduler_if;
    logic [3:0] i_Bouncy;
    logic [3:0] o_Debounced;
    logic       o_Event_Valid;
    logic [1:0] o_Event_Id;
    logic       i_Event_Ready;
    logic [3:0] o_Overrun;

    modport slave (
        input  i_Bouncy,
        input  i_Event_Ready,
        output o_Debounced,
        output o_Event_Valid,
        output o_Event_Id,
        output o_Overrun
    );

    modport master (
        output i_Bouncy,
        output i_Event_Ready,
        input  o_Debounced,
        input  o_Event_Valid,
        input  o_Event_Id,
        input  o_Overrun
    );
endinterface

`default_nettype wire

// File: rtl/button_event_scheduler.sv
// ============================================================================
// Module   : button_event_scheduler
// Brief    : Four-channel switch debouncer that queues press events and
//            offers them one at a time through a round-robin valid/ready port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module button_event_scheduler #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  wire logic                  i_Clk,
    input  wire logic                  i_Rst_L,
    button_event_scheduler_if.slave    bus
);

    localparam int              c_CW   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_LIMIT - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt [4];
    logic [3:0]      r_debounced;
    logic [3:0]      r_pending;
    logic [3:0]      r_overrun;
    logic [1:0]      r_ptr;
    logic [1:0]      r_event_id;
    logic            r_event_valid;

    logic [3:0]      w_press;
    logic [3:0]      w_clear;
    logic [1:0]      w_base;
    logic [1:0]      w_idx;
    logic [1:0]      w_winner;
    logic            w_found;
    logic            w_handshake;
    logic            w_load;

    // A press is the edge on which a low filtered level flips high.
    always_comb begin
        w_press = '0;
        for (int n = 0; n < 4; n++) begin
            w_press[n] = bus.i_Bouncy[n] & ~r_debounced[n] & (r_cnt[n] == c_LAST);
        end
    end

    // Search runs from the slot after the accepted id on a handshake, else from ptr.
    always_comb begin
        w_handshake = (r_state == ST_OFFER) && bus.i_Event_Ready;
        w_base      = (r_state == ST_OFFER) ? (r_event_id + 2'd1) : r_ptr;
        w_found     = 1'b0;
        w_winner    = w_base;
        w_idx       = w_base;
        for (int k = 3; k >= 0; k--) begin
            w_idx = w_base + 2'(k);
            if (r_pending[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
        w_load  = w_found && ((r_state == ST_IDLE) || w_handshake);
        w_clear = '0;
        if (w_load) begin
            w_clear[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            for (int n = 0; n < 4; n++) begin
                r_cnt[n] <= '0;
            end
            r_debounced <= '0;
            r_pending   <= '0;
            r_overrun   <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (bus.i_Bouncy[n] == r_debounced[n]) begin
                    r_cnt[n] <= '0;
                end else if (r_cnt[n] == c_LAST) begin
                    r_debounced[n] <= bus.i_Bouncy[n];
                    r_cnt[n]       <= '0;
                end else begin
                    r_cnt[n] <= r_cnt[n] + c_ONE;
                end
            end
            // A fresh press beats a same-edge load clear, and only counts as lost
            // when the older event is still waiting afterwards.
            r_overrun <= r_overrun | (w_press & r_pending & ~w_clear);
            r_pending <= (r_pending & ~w_clear) | w_press;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state       <= ST_IDLE;
            r_event_valid <= 1'b0;
            r_event_id    <= 2'd0;
            r_ptr         <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state       <= ST_OFFER;
                        r_event_valid <= 1'b1;
                        r_event_id    <= w_winner;
                    end
                end
                ST_OFFER: begin
                    if (w_handshake) begin
                        r_ptr <= r_event_id + 2'd1;
                        if (w_load) begin
                            r_event_id <= w_winner;
                        end else begin
                            r_state       <= ST_IDLE;
                            r_event_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_event_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Debounced   = r_debounced;
    assign bus.o_Event_Valid = r_event_valid;
    assign bus.o_Event_Id    = r_event_id;
    assign bus.o_Overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_button_event_scheduler.sv
// ============================================================================
// Module   : tb_button_event_scheduler
// Brief    : Directed vector table plus hand-written multi-cycle sequences for
//            the button event scheduler with a debounce limit of 4.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_event_scheduler;

    logic i_Clk;
    logic i_Rst_L;
    int   n_checks;
    int   n_fail;

    button_event_scheduler_if bus ();

    button_event_scheduler #(
        .DEBOUNCE_LIMIT (4)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .bus     (bus)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] b;
        logic       rdy;
        logic [3:0] deb;
        logic       val;
        logic [1:0] id;
        logic [3:0] ovr;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic rst_n, input logic [3:0] b, input logic rdy,
                       input logic [3:0] deb, input logic val, input logic [1:0] id,
                       input logic [3:0] ovr);
        vec_t v;
        v.rst_n = rst_n; v.b = b; v.rdy = rdy;
        v.deb = deb; v.val = val; v.id = id; v.ovr = ovr;
        tbl.push_back(v);
    endtask

    // Drive inputs, let n rising edges pass, then compare all outputs 1 ns later.
    task automatic run(input string name, input logic rst_n, input logic [3:0] b,
                       input logic rdy, input int n, input logic [3:0] e_deb,
                       input logic e_val, input logic [1:0] e_id, input logic [3:0] e_ovr);
        i_Rst_L           = rst_n;
        bus.i_Bouncy      = b;
        bus.i_Event_Ready = rdy;
        repeat (n) @(posedge i_Clk);
        #1;
        n_checks++;
        if (bus.o_Debounced !== e_deb || bus.o_Event_Valid !== e_val ||
            bus.o_Event_Id !== e_id || bus.o_Overrun !== e_ovr) begin
            n_fail++;
            $display("FAIL %s: got deb=%b val=%b id=%0d ovr=%b, required deb=%b val=%b id=%0d ovr=%b",
                     name, bus.o_Debounced, bus.o_Event_Valid, bus.o_Event_Id, bus.o_Overrun,
                     e_deb, e_val, e_id, e_ovr);
        end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        i_Rst_L           = 1'b0;
        bus.i_Bouncy      = 4'b0000;
        bus.i_Event_Ready = 1'b1;

        // reset
        add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0000);
        // glitch rejection on channel 0
        add(1, 4'b0001, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0001, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0001, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0001, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0001, 1, 4'b0001, 0, 2'd0, 4'b0000);
        add(1, 4'b0001, 1, 4'b0001, 1, 2'd0, 4'b0000);
        add(1, 4'b0001, 1, 4'b0001, 0, 2'd0, 4'b0000);
        // release: no event on the falling filtered edge
        add(1, 4'b0000, 1, 4'b0001, 0, 2'd0, 4'b0000);
        add(1, 4'b0000, 1, 4'b0001, 0, 2'd0, 4'b0000);
        add(1, 4'b0000, 1, 4'b0001, 0, 2'd0, 4'b0000);
        add(1, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0000);
        // short pulse on channel 2
        add(1, 4'b0100, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0100, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0100, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0000);
        // reset returns ptr to 0, then simultaneous presses on 0, 1, 3
        add(0, 4'b0000, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b1011, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b1011, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b1011, 1, 4'b0000, 0, 2'd0, 4'b0000);
        add(1, 4'b1011, 1, 4'b1011, 0, 2'd0, 4'b0000);
        add(1, 4'b1011, 1, 4'b1011, 1, 2'd0, 4'b0000);
        add(1, 4'b1011, 1, 4'b1011, 1, 2'd1, 4'b0000);
        add(1, 4'b1011, 1, 4'b1011, 1, 2'd3, 4'b0000);
        add(1, 4'b1011, 1, 4'b1011, 0, 2'd3, 4'b0000);
        add(1, 4'b0000, 1, 4'b1011, 0, 2'd3, 4'b0000);
        add(1, 4'b0000, 1, 4'b1011, 0, 2'd3, 4'b0000);
        add(1, 4'b0000, 1, 4'b1011, 0, 2'd3, 4'b0000);
        add(1, 4'b0000, 1, 4'b0000, 0, 2'd3, 4'b0000);

        foreach (tbl[i]) begin
            run($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].b, tbl[i].rdy, 1,
                tbl[i].deb, tbl[i].val, tbl[i].id, tbl[i].ovr);
        end

        // backpressure on channel 1 (ptr is 0 here)
        run("bp_press",     1, 4'b0010, 0, 4, 4'b0010, 0, 2'd3, 4'b0000);
        run("bp_offer",     1, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 4'b0000);
        run("bp_release1",  1, 4'b0000, 0, 4, 4'b0000, 1, 2'd1, 4'b0000);
        run("bp_repress1",  1, 4'b0010, 0, 4, 4'b0010, 1, 2'd1, 4'b0000);
        run("bp_release2",  1, 4'b0000, 0, 4, 4'b0000, 1, 2'd1, 4'b0000);
        run("bp_pre_ovr",   1, 4'b0010, 0, 3, 4'b0000, 1, 2'd1, 4'b0000);
        run("bp_overrun",   1, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 4'b0010);
        run("bp_hold",      1, 4'b0010, 0, 3, 4'b0010, 1, 2'd1, 4'b0010);
        run("bp_reoffer",   1, 4'b0010, 1, 1, 4'b0010, 1, 2'd1, 4'b0010);
        run("bp_drain",     1, 4'b0010, 1, 1, 4'b0010, 0, 2'd1, 4'b0010);

        // fairness: ptr is now 2, pending {0,3}
        run("fair_release", 1, 4'b0000, 1, 4, 4'b0000, 0, 2'd1, 4'b0010);
        run("fair_press",   1, 4'b1001, 1, 4, 4'b1001, 0, 2'd1, 4'b0010);
        run("fair_first",   1, 4'b1001, 1, 1, 4'b1001, 1, 2'd3, 4'b0010);
        run("fair_second",  1, 4'b1001, 1, 1, 4'b1001, 1, 2'd0, 4'b0010);
        run("fair_idle",    1, 4'b1001, 1, 1, 4'b1001, 0, 2'd0, 4'b0010);

        // reset during an offer discards it
        run("rst_release",  1, 4'b0000, 1, 4, 4'b0000, 0, 2'd0, 4'b0010);
        run("rst_offer",    1, 4'b0100, 0, 5, 4'b0100, 1, 2'd2, 4'b0010);
        run("rst_pulse",    0, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 4'b0000);
        run("rst_quiet",    1, 4'b0000, 1, 6, 4'b0000, 0, 2'd0, 4'b0000);

        // input held high through reset release is a new press
        run("held_rst",     0, 4'b0001, 1, 1, 4'b0000, 0, 2'd0, 4'b0000);
        run("held_count",   1, 4'b0001, 1, 3, 4'b0000, 0, 2'd0, 4'b0000);
        run("held_rise",    1, 4'b0001, 1, 1, 4'b0001, 0, 2'd0, 4'b0000);
        run("held_event",   1, 4'b0001, 1, 1, 4'b0001, 1, 2'd0, 4'b0000);
        run("held_done",    1, 4'b0001, 1, 1, 4'b0001, 0, 2'd0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
